// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-side memory bridges: FSM states, beat count
// and the lane-offset helper used to index 32-bit words inside a block.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BURST = 2'b01,
    RESP  = 2'b10
  } state_t;

  localparam int unsigned BEATS = 8;

  // LSB position of word lane idx inside a block made of width-bit words
  function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/block_mem_bridge.sv
// Data-side block bridge: serialises a 256-bit block request into eight 32-bit
// req/ack beats on the main-memory bus and answers with a one-cycle mem_ready.
module block_mem_bridge
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned BLOCK_SIZE = 256,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BLOCK_SIZE-1:0] mem_wr,
  input  logic                  mem_rw,
  input  logic                  mem_valid,
  output logic [BLOCK_SIZE-1:0] mem_rd,
  output logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic [DATA_WIDTH-1:0] dram_wdata,
  output logic                  dram_we,
  output logic                  dram_req,
  input  logic [DATA_WIDTH-1:0] dram_rdata,
  input  logic                  dram_ack,
  output logic                  bus_err
);

  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = ~ADDR_WIDTH'(BEATS - 1);

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    rw_q, rw_d;
  logic [BLOCK_SIZE-1:0]   wbuf_q, wbuf_d;
  logic [BLOCK_SIZE-1:0]   rbuf_q, rbuf_d;

  logic [BLOCK_SIZE-1:0]   mem_rd_d;
  logic                    mem_ready_d;
  logic [ADDR_WIDTH-1:0]   dram_addr_d;
  logic [DATA_WIDTH-1:0]   dram_wdata_d;
  logic                    dram_we_d;
  logic                    dram_req_d;
  logic                    bus_err_d;

  // Next-state, datapath and next-output logic; every output is registered
  // from the next state so no ack/rdata path reaches mem_ready or mem_rd.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    tmo_d        = tmo_q;
    base_d       = base_q;
    rw_d         = rw_q;
    wbuf_d       = wbuf_q;
    rbuf_d       = rbuf_q;
    bus_err_d    = bus_err;
    mem_rd_d     = '0;
    mem_ready_d  = 1'b0;
    dram_addr_d  = '0;
    dram_wdata_d = '0;
    dram_we_d    = 1'b0;
    dram_req_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          state_d = BURST;
          base_d  = mem_addr & BLK_MASK;
          rw_d    = mem_rw;
          wbuf_d  = mem_wr;
          rbuf_d  = '0;
          beat_d  = '0;
          tmo_d   = '0;
        end
      end
      BURST: begin
        if (dram_ack) begin
          tmo_d = '0;
          if (!rw_q) begin
            rbuf_d[lane_lsb(32'(beat_q), DATA_WIDTH) +: DATA_WIDTH] = dram_rdata;
          end
          if (beat_q == LAST_BEAT) begin
            state_d = RESP;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          // Abort: report an empty block and flag the bus as unreliable
          state_d   = RESP;
          rbuf_d    = '0;
          bus_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == BURST) begin
      dram_req_d   = 1'b1;
      dram_we_d    = rw_d;
      dram_addr_d  = base_d | ADDR_WIDTH'(beat_d);
      dram_wdata_d = wbuf_d[lane_lsb(32'(beat_d), DATA_WIDTH) +: DATA_WIDTH];
    end

    if (state_d == RESP) begin
      mem_ready_d = 1'b1;
      mem_rd_d    = rw_d ? '0 : rbuf_d;
    end
  end

  // State, buffers, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      tmo_q      <= '0;
      base_q     <= '0;
      rw_q       <= 1'b0;
      wbuf_q     <= '0;
      rbuf_q     <= '0;
      mem_rd     <= '0;
      mem_ready  <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      dram_we    <= 1'b0;
      dram_req   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      tmo_q      <= tmo_d;
      base_q     <= base_d;
      rw_q       <= rw_d;
      wbuf_q     <= wbuf_d;
      rbuf_q     <= rbuf_d;
      mem_rd     <= mem_rd_d;
      mem_ready  <= mem_ready_d;
      dram_addr  <= dram_addr_d;
      dram_wdata <= dram_wdata_d;
      dram_we    <= dram_we_d;
      dram_req   <= dram_req_d;
      bus_err    <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_block_mem_bridge.sv
// Directed bench for block_mem_bridge (TIMEOUT = 4): table-driven transfers
// plus hand-written back-to-back, timeout and mid-burst reset sequences.
module tb_block_mem_bridge;

  logic         clk;
  logic         rst;
  logic [27:0]  mem_addr;
  logic [255:0] mem_wr;
  logic         mem_rw;
  logic         mem_valid;
  logic [255:0] mem_rd;
  logic         mem_ready;
  logic [27:0]  dram_addr;
  logic [31:0]  dram_wdata;
  logic         dram_we;
  logic         dram_req;
  logic [31:0]  dram_rdata;
  logic         dram_ack;
  logic         bus_err;

  int total = 0;
  int bad   = 0;
  logic err_model = 1'b0;

  block_mem_bridge #(
    .ADDR_WIDTH(28),
    .BLOCK_SIZE(256),
    .DATA_WIDTH(32),
    .TIMEOUT   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_rw    (mem_rw),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_ready (mem_ready),
    .dram_addr (dram_addr),
    .dram_wdata(dram_wdata),
    .dram_we   (dram_we),
    .dram_req  (dram_req),
    .dram_rdata(dram_rdata),
    .dram_ack  (dram_ack),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [27:0] addr;
    logic        rw;
    logic [31:0] seed;
    int          wait_cyc;
    logic [27:0] exp_base;
  } vec_t;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, " mem_ready"}, 256'(mem_ready), 256'(0));
    chk({nm, " mem_rd"}, mem_rd, 256'(0));
    chk({nm, " dram_req"}, 256'(dram_req), 256'(0));
    chk({nm, " dram_we"}, 256'(dram_we), 256'(0));
    chk({nm, " dram_addr"}, 256'(dram_addr), 256'(0));
    chk({nm, " dram_wdata"}, 256'(dram_wdata), 256'(0));
  endtask

  // Full transfer starting from an IDLE cycle; ends in the RESP cycle.
  task automatic run_txn(input vec_t v, input bit hold);
    logic [255:0] exp_rd;
    mem_valid = 1'b1;
    mem_rw    = v.rw;
    mem_addr  = v.addr;
    exp_rd    = '0;
    for (int i = 0; i < 8; i++) begin
      mem_wr[32*i +: 32] = v.seed + 32'(i);
      if (!v.rw) exp_rd[32*i +: 32] = v.seed + 32'(i);
    end
    cyc();
    for (int k = 0; k < 8; k++) begin
      for (int w = 0; w <= v.wait_cyc; w++) begin
        chk($sformatf("%s b%0d w%0d req", v.name, k, w), 256'(dram_req), 256'(1));
        chk($sformatf("%s b%0d w%0d addr", v.name, k, w), 256'(dram_addr), 256'(v.exp_base + 28'(k)));
        chk($sformatf("%s b%0d w%0d we", v.name, k, w), 256'(dram_we), 256'(v.rw));
        if (v.rw)
          chk($sformatf("%s b%0d w%0d wdata", v.name, k, w), 256'(dram_wdata), 256'(v.seed + 32'(k)));
        chk($sformatf("%s b%0d w%0d ready", v.name, k, w), 256'(mem_ready), 256'(0));
        chk($sformatf("%s b%0d w%0d rd", v.name, k, w), mem_rd, 256'(0));
        if (w == v.wait_cyc) begin
          dram_ack   = 1'b1;
          dram_rdata = v.rw ? (32'hDEAD_0000 + 32'(k)) : (v.seed + 32'(k));
        end
        cyc();
        dram_ack   = 1'b0;
        dram_rdata = 32'h0;
      end
    end
    chk({v.name, " resp ready"}, 256'(mem_ready), 256'(1));
    chk({v.name, " resp rd"}, mem_rd, exp_rd);
    chk({v.name, " resp req"}, 256'(dram_req), 256'(0));
    chk({v.name, " resp bus_err"}, 256'(bus_err), 256'(err_model));
    if (!hold) mem_valid = 1'b0;
  endtask

  vec_t vecs[4];
  vec_t v;

  initial begin
    vecs[0] = '{"rd_ack0",  28'h0001238, 1'b0, 32'hA000_0000, 0, 28'h0001238};
    vecs[1] = '{"wr_ack2",  28'h0004560, 1'b1, 32'h5500_0000, 1, 28'h0004560};
    vecs[2] = '{"rd_unal",  28'h0ABCDEF, 1'b0, 32'h3C00_0000, 1, 28'h0ABCDE8};
    vecs[3] = '{"wr_top",   28'hFFFFFFF, 1'b1, 32'h1234_5670, 0, 28'hFFFFFF8};

    rst = 1'b1;
    mem_addr = '0; mem_wr = '0; mem_rw = 1'b0; mem_valid = 1'b0;
    dram_rdata = '0; dram_ack = 1'b0;
    cyc(); cyc();
    chk_quiet("reset");
    chk("reset bus_err", 256'(bus_err), 256'(0));
    rst = 1'b0;
    cyc();
    chk_quiet("idle");

    for (int i = 0; i < 4; i++) begin
      run_txn(vecs[i], 1'b0);
      cyc();
      chk_quiet($sformatf("post %s", vecs[i].name));
    end

    // Write-back followed by allocate with mem_valid held through mem_ready
    v = '{"b2b_wr", 28'h0002000, 1'b1, 32'h7700_0000, 0, 28'h0002000};
    run_txn(v, 1'b1);
    mem_rw   = 1'b0;
    mem_addr = 28'h0003008;
    cyc();
    chk_quiet("b2b idle");
    v = '{"b2b_rd", 28'h0003008, 1'b0, 32'h8800_0000, 0, 28'h0003008};
    run_txn(v, 1'b0);
    cyc();

    // Timeout: ack beats 0..2, then silence for TIMEOUT cycles
    mem_valid = 1'b1; mem_rw = 1'b0; mem_addr = 28'h0000100;
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tmo b%0d addr", k), 256'(dram_addr), 256'(28'h0000100 + 28'(k)));
      dram_ack = 1'b1; dram_rdata = 32'hC0DE_0000 + 32'(k);
      cyc();
      dram_ack = 1'b0;
    end
    for (int w = 1; w <= 4; w++) begin
      chk($sformatf("tmo wait%0d req", w), 256'(dram_req), 256'(1));
      chk($sformatf("tmo wait%0d addr", w), 256'(dram_addr), 256'(28'h0000103));
      chk($sformatf("tmo wait%0d ready", w), 256'(mem_ready), 256'(0));
      chk($sformatf("tmo wait%0d bus_err", w), 256'(bus_err), 256'(0));
      cyc();
    end
    chk("tmo ready", 256'(mem_ready), 256'(1));
    chk("tmo rd", mem_rd, 256'(0));
    chk("tmo bus_err", 256'(bus_err), 256'(1));
    chk("tmo req", 256'(dram_req), 256'(0));
    err_model = 1'b1;
    mem_valid = 1'b0;
    cyc();
    chk("tmo idle bus_err", 256'(bus_err), 256'(1));
    run_txn(vecs[0], 1'b0);
    cyc();
    run_txn(vecs[1], 1'b0);
    cyc();

    // Reset asserted during beat 5 of a read
    mem_valid = 1'b1; mem_rw = 1'b0; mem_addr = 28'h0000400;
    cyc();
    for (int k = 0; k < 5; k++) begin
      dram_ack = 1'b1; dram_rdata = 32'hBEEF_0000 + 32'(k);
      cyc();
      dram_ack = 1'b0;
    end
    chk("rst beat5 addr", 256'(dram_addr), 256'(28'h0000405));
    mem_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_quiet("async rst");
    chk("async rst bus_err", 256'(bus_err), 256'(0));
    err_model = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    dram_ack = 1'b1; dram_rdata = 32'hFFFF_FFFF;
    cyc();
    dram_ack = 1'b0; dram_rdata = 32'h0;
    chk_quiet("stray ack");
    cyc();
    v = '{"after_rst", 28'h0000400, 1'b0, 32'h6600_0000, 0, 28'h0000400};
    run_txn(v, 1'b0);
    cyc();
    chk_quiet("final idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/block_mem_bridge.md
# block_mem_bridge

Memory-side bridge between the data-cache controller's 256-bit block port and the 32-bit word-wide main-memory bus. Each block request is serialised into 8 word transfers with a per-word req/ack handshake. The bridge answers the controller with a single-cycle `mem_ready` pulse, carrying the assembled block on reads. An ack-timeout guard guarantees the controller is never left hanging.

## Interface
- `ADDR_WIDTH`, 28: word address width on both sides.
- `BLOCK_SIZE`, 256: block width in bits.
- `DATA_WIDTH`, 32: memory bus word width; `BEATS = BLOCK_SIZE/DATA_WIDTH` (8).
- `TIMEOUT`, 255: max BURST cycles without `dram_ack` before abort.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_addr` in 28: block word address from controller; bits [2:0] ignored.
- `mem_wr` in 256: write block; word k = bits [32k+31:32k].
- `mem_rw` in 1: 1 = write-back, 0 = allocate (read).
- `mem_valid` in 1: request, level; held until `mem_ready`.
- `mem_rd` out 256: read block, valid only while `mem_ready` = 1.
- `mem_ready` out 1: one-cycle completion pulse.
- `dram_addr` out 28: word address.
- `dram_wdata` out 32: write word.
- `dram_we` out 1: 1 = write beat.
- `dram_req` out 1: beat request, held until ack.
- `dram_rdata` in 32: read word, sampled on `dram_ack`.
- `dram_ack` in 1: beat complete, one-cycle pulse.
- `bus_err` out 1: sticky timeout flag.

## Operation
States:
- **IDLE**
  - On `mem_valid`: latch base = {`mem_addr`[27:3], 3'b0}, `mem_wr` into wbuf, and `mem_rw`.
  - Clear beat counter and timeout counter; go to BURST.
- **BURST**
  - Drive `dram_req` = 1, `dram_addr` = {base[27:3], beat}, `dram_we` = latched rw, `dram_wdata` = wbuf word[beat].
  - On `dram_ack`: if read, rbuf word[beat] ← `dram_rdata`; clear the timeout counter.
  - On `dram_ack` with beat == 7: go to RESP. Otherwise beat increments.
  - Without `dram_ack`: timeout counter increments. When it reaches `TIMEOUT`, set `bus_err` and go to RESP with rbuf cleared to 0.
- **RESP**
  - `mem_ready` = 1.
  - `mem_rd` = rbuf for reads, 256'h0 for writes.
  - Go to IDLE unconditionally.

Rules:
- Beat counter is 3 bits; it never wraps inside a burst (exit occurs at 7).
- Outside BURST: `dram_req`, `dram_we`, `dram_addr`, `dram_wdata` = 0.
- Outside RESP: `mem_ready` = 0 and `mem_rd` = 0.
- Inputs `mem_addr`/`mem_wr`/`mem_rw` are not sampled after IDLE.
- Back-to-back requests: the controller advances on the `mem_ready` edge. A request still or newly valid in the following IDLE cycle is a new request and is accepted there (flush write-back streams, write-back→allocate).
- `dram_ack` outside BURST is ignored.
- Reset, including mid-burst: state IDLE; all outputs 0; `bus_err` cleared; buffers and counters cleared; the in-flight request is dropped. The controller is reset in the same domain.

## Timing
- Let `mem_valid` be seen in IDLE in cycle t.
- BURST starts at t+1.
- With `dram_ack` returned in the same cycle as each req, beats occupy t+1..t+8, RESP is at t+9, and the next accept is possible at t+10.
- Each wait cycle without ack adds 1 cycle.
- Timeout abort: RESP occurs `TIMEOUT`+1 cycles after the last ack or burst start.
- `bus_err` rises in the RESP cycle of the aborted transfer and stays high until `rst`.
- No combinational path from `dram_ack` or `dram_rdata` to `mem_ready` or `mem_rd`.

## Structure
- Shared package `mem_if_pkg` holds:
  - state localparams IDLE=2'b00, BURST=2'b01, RESP=2'b10;
  - `BEATS`;
  - the word-select helper for 256↔32 lane indexing.
- Package is reused by the instruction-side bridge.
- No sub-module. FSM, beat/timeout counters and the two 256-bit buffers live in one module.

## Test plan
- **Read, ack every cycle.** Read at `mem_addr` = 28'h0001238, memory word i = 32'hA000_0000+i. Required:
  - `dram_addr` 28'h0001238..28'h000123F on t+1..t+8;
  - `mem_ready` at t+9 with `mem_rd` word i = 32'hA000_0000+i.
- **Write with 2-cycle ack.** Write `mem_wr` word i = 32'h5500_0000+i. Required:
  - each beat held 2 cycles with `dram_we` = 1 and `dram_wdata` matching;
  - `mem_ready` at t+17 with `mem_rd` = 0.
- **Write-back then allocate.** Keep `mem_valid` high and change `mem_rw` 1→0 on the `mem_ready` edge. Required: the second burst starts the cycle after IDLE, and no beat is duplicated.
- **Timeout.** With `TIMEOUT` = 4, stop `dram_ack` after beat 2. Required:
  - `mem_ready` 5 cycles after the last ack;
  - `mem_rd` = 0;
  - `bus_err` = 1 and stays 1 across further good transfers.
- **Reset mid-burst.** Assert `rst` during beat 5. Required: all outputs 0 immediately (async). After release, a stray `dram_ack` is ignored and a new read completes normally.
